// File: rtl/iob_ram_tdp_be_ctrl.sv
// Single-clock true dual-port RAM with byte enables, 1/2-cycle read latency,
// sticky cross-port write-collision flag and an optional zero-fill engine (IOB_RAM_TDP_BE_CTRL_CLEAR_EN).
module iob_ram_tdp_be_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                enA_i,
  input  logic [DATA_W/8-1:0] weA_i,
  input  logic [ADDR_W-1:0]   addrA_i,
  input  logic [DATA_W-1:0]   dA_i,
  output logic [DATA_W-1:0]   dA_o,
  output logic                rvalidA_o,
  input  logic                enB_i,
  input  logic [DATA_W/8-1:0] weB_i,
  input  logic [ADDR_W-1:0]   addrB_i,
  input  logic [DATA_W-1:0]   dB_i,
  output logic [DATA_W-1:0]   dB_o,
  output logic                rvalidB_o,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                coll_o,
  input  logic                coll_clr_i
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef IOB_RAM_TDP_BE_CTRL_CLEAR_EN
  // state  | meaning
  // IDLE   | ports serviced, waiting for clear_i
  // CLEAR  | writing zero to mem[cnt], ports ignored
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (clear_i) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == {ADDR_W{1'b1}}) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = cnt;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign busy         = 1'b0;
  assign clr_we       = 1'b0;
  assign clr_addr     = '0;
`endif

  assign busy_o = busy;

  logic          acc_a, acc_b, rd_a, rd_b;
  logic [NB-1:0] we_a, we_b;

  assign acc_a = enA_i & ~busy;
  assign acc_b = enB_i & ~busy;
  assign we_a  = acc_a ? weA_i : '0;
  assign we_b  = acc_b ? weB_i : '0;
  assign rd_a  = acc_a & (weA_i == '0);
  assign rd_b  = acc_b & (weB_i == '0);

  // Port A is written last so it owns any byte both ports enable.
  always_ff @(posedge clk_i) begin
    if (clr_we) mem[clr_addr] <= '0;
    for (int k = 0; k < NB; k++) begin
      if (we_b[k]) mem[addrB_i][k*8 +: 8] <= dB_i[k*8 +: 8];
    end
    for (int k = 0; k < NB; k++) begin
      if (we_a[k]) mem[addrA_i][k*8 +: 8] <= dA_i[k*8 +: 8];
    end
  end

  logic [DATA_W-1:0] q1_a, q1_b;
  logic              v1_a, v1_b;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      q1_a <= '0;
      q1_b <= '0;
      v1_a <= 1'b0;
      v1_b <= 1'b0;
    end else begin
      v1_a <= rd_a;
      v1_b <= rd_b;
      if (rd_a) q1_a <= mem[addrA_i];
      if (rd_b) q1_b <= mem[addrB_i];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] q2_a, q2_b;
      logic              v2_a, v2_b;

      always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
          q2_a <= '0;
          q2_b <= '0;
          v2_a <= 1'b0;
          v2_b <= 1'b0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) q2_a <= q1_a;
          if (v1_b) q2_b <= q1_b;
        end
      end

      assign dA_o      = q2_a;
      assign dB_o      = q2_b;
      assign rvalidA_o = v2_a;
      assign rvalidB_o = v2_b;
    end else begin : g_lat1
      assign dA_o      = q1_a;
      assign dB_o      = q1_b;
      assign rvalidA_o = v1_a;
      assign rvalidB_o = v1_b;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      coll_o <= 1'b0;
    end else if ((addrA_i == addrB_i) && ((we_a & we_b) != '0)) begin
      coll_o <= 1'b1;
    end else if (coll_clr_i) begin
      coll_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iob_ram_tdp_be_ctrl.sv
// Directed bench for iob_ram_tdp_be_ctrl: one READ_LAT=1 and one READ_LAT=2
// instance share stimulus; clear-engine checks follow IOB_RAM_TDP_BE_CTRL_CLEAR_EN.
module tb_iob_ram_tdp_be_ctrl;

`ifdef IOB_RAM_TDP_BE_CTRL_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b, clear, coll_clr;
  logic [3:0]  we_a, we_b, addr_a, addr_b;
  logic [31:0] d_a, d_b;
  logic [31:0] da1, db1, da2, db2;
  logic        va1, vb1, va2, vb2, busy1, busy2, coll1, coll2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_ram_tdp_be_ctrl #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1)) dut1 (
    .clk_i(clk), .arst_n_i(rst_n),
    .enA_i(en_a), .weA_i(we_a), .addrA_i(addr_a), .dA_i(d_a), .dA_o(da1), .rvalidA_o(va1),
    .enB_i(en_b), .weB_i(we_b), .addrB_i(addr_b), .dB_i(d_b), .dB_o(db1), .rvalidB_o(vb1),
    .clear_i(clear), .busy_o(busy1), .coll_o(coll1), .coll_clr_i(coll_clr));

  iob_ram_tdp_be_ctrl #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2)) dut2 (
    .clk_i(clk), .arst_n_i(rst_n),
    .enA_i(en_a), .weA_i(we_a), .addrA_i(addr_a), .dA_i(d_a), .dA_o(da2), .rvalidA_o(va2),
    .enB_i(en_b), .weB_i(we_b), .addrB_i(addr_b), .dB_i(d_b), .dB_o(db2), .rvalidB_o(vb2),
    .clear_i(clear), .busy_o(busy2), .coll_o(coll2), .coll_clr_i(coll_clr));

  typedef struct {
    logic        ea;
    logic [3:0]  wa, aa;
    logic [31:0] da;
    logic        eb;
    logic [3:0]  wb, ab;
    logic [31:0] db;
    logic        cl;
    logic [31:0] xa;
    logic        xva;
    logic [31:0] xb;
    logic        xvb;
    logic        xc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                              input logic [31:0] da, input logic eb, input logic [3:0] wb,
                              input logic [3:0] ab, input logic [31:0] db, input logic cl,
                              input logic [31:0] xa, input logic xva, input logic [31:0] xb,
                              input logic xvb, input logic xc);
    vec_t v;
    v.ea = ea; v.wa = wa; v.aa = aa; v.da = da;
    v.eb = eb; v.wb = wb; v.ab = ab; v.db = db; v.cl = cl;
    v.xa = xa; v.xva = xva; v.xb = xb; v.xvb = xvb; v.xc = xc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    en_a = 0; we_a = '0; addr_a = '0; d_a = '0;
    en_b = 0; we_b = '0; addr_b = '0; d_b = '0;
    clear = 0; coll_clr = 0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (busy1 && n < 40) begin
      tick;
      n++;
    end
    chk(name, 32'(n), CLR_EN ? 32'd16 : 32'd0);
  endtask

  task automatic read_a(input logic [3:0] a, input logic [31:0] exp, input string name);
    en_a = 1; we_a = '0; addr_a = a;
    tick;
    en_a = 0;
    chkb({name, " va1"}, va1, 1'b1);
    chk({name, " da1"}, da1, exp);
    chkb({name, " va2 early"}, va2, 1'b0);
    tick;
    chkb({name, " va1 pulse"}, va1, 1'b0);
    chkb({name, " va2"}, va2, 1'b1);
    chk({name, " da2"}, da2, exp);
  endtask

  initial begin
    logic [31:0] pa, pb;
    logic        pva, pvb;
    int          nb;

    // write A, overwrite B, then read both ports back-to-back
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 4'hF, 4'(i), 32'h20 + 32'(i), 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 1, 4'hF, 4'(i), 32'h40 + 32'(i), 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 4'h0, 4'(i), 0, 1, 4'h0, 4'(15 - i), 0, 0,
                        32'h40 + 32'(i), 1, 32'h40 + 32'(15 - i), 1, 0));
    vecs.push_back(mk(1, 4'h3, 4'd5, 32'h11111111, 1, 4'h6, 4'd5, 32'h22222222, 0,
                      32'h4F, 0, 32'h40, 0, 1));
    vecs.push_back(mk(1, 4'h0, 4'd5, 0, 1, 4'h0, 4'd5, 0, 0,
                      32'h00221111, 1, 32'h00221111, 1, 1));
    vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 4'h0, 4'd0, 0, 1,
                      32'h00221111, 0, 32'h00221111, 0, 0));
    vecs.push_back(mk(1, 4'hF, 4'd9, 32'h99, 1, 4'h1, 4'd9, 32'h77, 1,
                      32'h00221111, 0, 32'h00221111, 0, 1));
    vecs.push_back(mk(0, 4'h0, 4'd0, 0, 1, 4'h0, 4'd9, 0, 1,
                      32'h00221111, 0, 32'h99, 1, 0));
    vecs.push_back(mk(1, 4'h1, 4'd3, 32'h000000CC, 1, 4'h8, 4'd3, 32'hDD000000, 0,
                      32'h00221111, 0, 32'h99, 0, 0));
    vecs.push_back(mk(1, 4'hF, 4'd2, 32'h12, 1, 4'hF, 4'd4, 32'h34, 0,
                      32'h00221111, 0, 32'h99, 0, 0));
    vecs.push_back(mk(1, 4'h0, 4'd3, 0, 1, 4'h0, 4'd2, 0, 0,
                      32'hDD0000CC, 1, 32'h12, 1, 0));
    vecs.push_back(mk(1, 4'h0, 4'd4, 0, 0, 4'h0, 4'd0, 0, 0, 32'h34, 1, 32'h12, 0, 0));
    vecs.push_back(mk(1, 4'hF, 4'd7, 32'hAAAA5555, 0, 4'h0, 4'd0, 0, 0, 32'h34, 0, 32'h12, 0, 0));
    vecs.push_back(mk(1, 4'h0, 4'd7, 0, 1, 4'hF, 4'd7, 32'h12345678, 0,
                      32'hAAAA5555, 1, 32'h12, 0, 0));
    vecs.push_back(mk(1, 4'h0, 4'd7, 0, 0, 4'h0, 4'd0, 0, 0, 32'h12345678, 1, 32'h12, 0, 0));
    vecs.push_back(mk(1, 4'hF, 4'd7, 32'h0BADF00D, 1, 4'h0, 4'd7, 0, 0,
                      32'h12345678, 0, 32'h12345678, 1, 0));
    vecs.push_back(mk(0, 4'hF, 4'd7, 32'hFFFFFFFF, 1, 4'h0, 4'd7, 0, 0,
                      32'h12345678, 0, 32'h0BADF00D, 1, 0));
    vecs.push_back(mk(1, 4'h0, 4'd7, 0, 0, 4'h0, 4'd0, 0, 0,
                      32'h0BADF00D, 1, 32'h0BADF00D, 0, 0));

    set_idle;
    rst_n = 0;
    #12;
    chk("reset da1", da1, 0);
    chk("reset db2", db2, 0);
    chkb("reset va1", va1, 0);
    chkb("reset vb2", vb2, 0);
    chkb("reset coll1", coll1, 0);
    chkb("reset busy1", busy1, CLR_EN);
    chkb("reset busy2", busy2, CLR_EN);
    #1 rst_n = 1;
    wait_busy("startup busy cycles");

    pa = 0; pb = 0; pva = 0; pvb = 0;
    foreach (vecs[i]) begin
      en_a = vecs[i].ea; we_a = vecs[i].wa; addr_a = vecs[i].aa; d_a = vecs[i].da;
      en_b = vecs[i].eb; we_b = vecs[i].wb; addr_b = vecs[i].ab; d_b = vecs[i].db;
      coll_clr = vecs[i].cl;
      tick;
      chk($sformatf("v%0d da1", i), da1, vecs[i].xa);
      chkb($sformatf("v%0d va1", i), va1, vecs[i].xva);
      chk($sformatf("v%0d db1", i), db1, vecs[i].xb);
      chkb($sformatf("v%0d vb1", i), vb1, vecs[i].xvb);
      chkb($sformatf("v%0d coll1", i), coll1, vecs[i].xc);
      chk($sformatf("v%0d da2", i), da2, pa);
      chkb($sformatf("v%0d va2", i), va2, pva);
      chk($sformatf("v%0d db2", i), db2, pb);
      chkb($sformatf("v%0d vb2", i), vb2, pvb);
      chkb($sformatf("v%0d coll2", i), coll2, vecs[i].xc);
      chkb($sformatf("v%0d busy1", i), busy1, 1'b0);
      pa = vecs[i].xa; pva = vecs[i].xva; pb = vecs[i].xb; pvb = vecs[i].xvb;
    end
    set_idle;
    tick;

    // fill, request clear with a B read in the same cycle, then try an A read while busy
    for (int i = 0; i < 16; i++) begin
      en_a = 1; we_a = 4'hF; addr_a = 4'(i); d_a = 32'h20 + 32'(i);
      tick;
    end
    set_idle;
    clear = 1; en_b = 1; addr_b = 4'd1;
    tick;
    set_idle;
    nb = busy1 ? 1 : 0;
    chkb("clr edge vb1", vb1, 1'b1);
    chk("clr edge db1", db1, 32'h21);
    en_a = 1; addr_a = 4'd3;
    tick;
    set_idle;
    if (busy1) nb++;
    chkb("busy read va1", va1, !CLR_EN);
    chkb("inflight vb2", vb2, 1'b1);
    chk("inflight db2", db2, 32'h21);
    tick;
    if (busy1) nb++;
    chkb("busy read va2", va2, !CLR_EN);
    for (int i = 0; i < 17; i++) begin
      tick;
      if (busy1) nb++;
    end
    chk("clear busy cycles", 32'(nb), CLR_EN ? 32'd16 : 32'd0);
    chkb("busy low after clear", busy1, 1'b0);
    for (int i = 0; i < 16; i++)
      read_a(4'(i), CLR_EN ? 32'h0 : 32'h20 + 32'(i), $sformatf("post-clear a%0d", i));

`ifdef IOB_RAM_TDP_BE_CTRL_CLEAR_EN
    // reset while the clear engine is at address 8 must restart a full fill
    en_a = 1; we_a = 4'hF; addr_a = 4'd12; d_a = 32'hCAFEF00D;
    tick;
    set_idle;
    clear = 1;
    tick;
    clear = 0;
    for (int i = 0; i < 8; i++) tick;
    rst_n = 0;
    #2;
    chkb("mid-clear reset busy", busy1, 1'b1);
    chkb("mid-clear reset va2", va2, 1'b0);
    #2 rst_n = 1;
    wait_busy("restart busy cycles");
    read_a(4'd12, 32'h0, "restart a12");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iob_ram_tdp_be_ctrl.md
# iob_ram_tdp_be_ctrl

Single-clock true dual-port RAM with per-byte write enables, configurable read latency, a hardware clear engine and cross-port write-collision detection. Used wherever two masters in the same clock domain share a buffer (DMA/CPU scratchpads, packet buffers) and need defined contents after reset and defined behaviour on address conflicts. It is the single-clock, controlled successor of the plain dual-port byte-enable RAM.

## Interface
- DATA_W, 32, word width; multiple of 8.
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- clk_i  input  1  clock, all logic on rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- enA_i  input  1  port A access enable.
- weA_i  input  DATA_W/8  port A byte write enables; 0 with enA_i=1 means read.
- addrA_i  input  ADDR_W  port A address.
- dA_i  input  DATA_W  port A write data.
- dA_o  output  DATA_W  port A read data.
- rvalidA_o  output  1  port A read data valid, one-cycle pulse.
- enB_i, weB_i, addrB_i, dB_i, dB_o, rvalidB_o: port B, identical to A.
- clear_i  input  1  request zero-fill of whole array.
- busy_o  output  1  clear engine active; ports ignored.
- coll_o  output  1  sticky write-collision flag.
- coll_clr_i  input  1  clears coll_o.

## Operation
- Accepted access: enX_i=1 and busy_o=0. Accesses while busy_o=1 are dropped: no write, no rvalid.
- Read (weX_i=0): dX_o updated and rvalidX_o pulsed exactly READ_LAT cycles after acceptance. dX_o holds last read value otherwise; writes never change dX_o.
- Write: bytes with weX_i[k]=1 updated at the accept edge; no rvalid.
- Both ports write same address same cycle: per byte, A wins where both enables set; B's non-overlapping bytes still written. If (weA_i & weB_i)!=0, coll_o sets next cycle.
- Read on one port, write on other, same address same cycle: read returns old data (read-first).
- coll_o stays set until coll_clr_i=1; set and clear in same cycle: set wins.
- Clear engine FSM: IDLE -> CLEAR on clear_i=1 (in IDLE). CLEAR writes 0 to address cnt, cnt increments 0..2**ADDR_W-1, then -> IDLE. clear_i while in CLEAR ignored. Reads in flight when CLEAR starts still complete.
- Array contents not reset by arst_n_i.

## Timing
- Reset values: dA_o=dB_o=0, rvalidA_o=rvalidB_o=0, coll_o=0, cnt=0; busy_o per Configuration.
- busy_o asserts cycle after clear_i sampled, stays high exactly 2**ADDR_W cycles, drops after last address written; first access accepted the cycle busy_o is low.
- READ_LAT=2: one internal output register stage; back-to-back reads give one rvalid per cycle, no bubbles.
- Reset asserted mid-CLEAR: FSM aborts asynchronously, restarts from address 0 per Configuration after release; pending rvalids discarded.

## Configuration
- IOB_RAM_TDP_BE_CTRL_CLEAR_EN defined: clear engine present; busy_o resets to 1 and FSM resets into CLEAR (automatic zero-fill after every reset, 2**ADDR_W cycles); clear_i functional.
- Undefined: no clear engine; busy_o tied 0, clear_i ignored, contents undefined after power-up; ports usable first cycle after reset release.

## Test plan
- Clear enabled, DATA_W=32, ADDR_W=4: release reset -> busy_o high 16 cycles; then read addresses 0..15 on A -> all 0x00000000, rvalidA_o one cycle after each.
- Write A 0x20+i to addr i (weA_i=0xF), write B 0x40+i to addr i then read both ports -> both see 0x40+i; READ_LAT=2 rerun -> data two cycles after request, back-to-back valid.
- Same cycle addr 5: A writes 0x11111111 weA_i=0x3, B writes 0x22222222 weB_i=0x6 -> addr 5 = 0x00221111 low bytes (byte1 from A), byte2 0x22; coll_o=1; coll_clr_i pulse -> coll_o=0; simultaneous new collision + clear -> coll_o stays 1.
- Addr 7 holds 0xAAAA5555; A reads 7 while B writes 0x12345678 same cycle -> dA_o=0xAAAA5555; next A read -> 0x12345678.
- clear_i after filling array, A read issued during busy_o -> no rvalidA_o; after busy_o drops all reads return 0; arst_n_i pulse at clear address 8 -> busy_o restarts, full 16 cycles.
- Clear disabled build: busy_o=0 throughout, clear_i=1 has no effect on previously written 0x20+i data.
